// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: load-type encodings, register zero and datapath width.
package mips_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment: selects the half/byte addressed by the load and extends it.
module load_align
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] readData,
    input  logic [2:0]        loadType,
    input  logic [1:0]        byteOffset,
    output logic [DATA_W-1:0] aligned
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = byteOffset[1] ? readData[31:16] : readData[15:0];
        case (byteOffset)
            2'd0:    byte_sel = readData[7:0];
            2'd1:    byte_sel = readData[15:8];
            2'd2:    byte_sel = readData[23:16];
            default: byte_sel = readData[31:24];
        endcase
    end

    // Unused encodings 5-7 fall through to a full-word load.
    always_comb begin
        case (loadType)
            LT_LH:   aligned = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  aligned = {16'h0000, half_sel};
            LT_LB:   aligned = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  aligned = {24'h000000, byte_sel};
            default: aligned = readData;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, load alignment and retire counter feeding the register file.
// Define WB_FORWARD_EN to add the combinational decode bypass ports.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int unsigned RETIRE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    memValid,
    input  logic                    memRegWrite,
    input  logic                    memMemToReg,
    input  logic [2:0]              memLoadType,
    input  logic [1:0]              memByteOffset,
    input  logic [4:0]              memWriteAddr,
    input  logic [DATA_W-1:0]       memAluResult,
    input  logic [DATA_W-1:0]       memReadData,
    output logic [4:0]              writeAddr,
    output logic [DATA_W-1:0]       writedata,
    output logic                    writeEnable,
`ifdef WB_FORWARD_EN
    input  logic [4:0]              addr1,
    input  logic [4:0]              addr2,
    output logic                    fwd1,
    output logic                    fwd2,
    output logic [DATA_W-1:0]       fwdData1,
    output logic [DATA_W-1:0]       fwdData2,
`endif
    output logic [RETIRE_WIDTH-1:0] retired
);

    logic              capture;
    logic [DATA_W-1:0] load_data;

    // flush wins over a valid instruction: the slot becomes a bubble.
    assign capture = memValid & ~flush;

    load_align u_load_align (
        .readData   (memReadData),
        .loadType   (memLoadType),
        .byteOffset (memByteOffset),
        .aligned    (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeAddr   <= REG_ZERO;
            writedata   <= '0;
            writeEnable <= 1'b0;
            retired     <= '0;
        end else begin
            writeAddr   <= memWriteAddr;
            writedata   <= memMemToReg ? load_data : memAluResult;
            writeEnable <= capture & memRegWrite & (memWriteAddr != REG_ZERO);
            if (capture) begin
                retired <= retired + RETIRE_WIDTH'(1);
            end
        end
    end

`ifdef WB_FORWARD_EN
    // $0 cannot match: writeEnable is already cleared for it.
    assign fwd1     = writeEnable & (writeAddr == addr1);
    assign fwd2     = writeEnable & (writeAddr == addr2);
    assign fwdData1 = fwd1 ? writedata : '0;
    assign fwdData2 = fwd2 ? writedata : '0;
`else
    // Without the bypass, decode waits for the register file to commit.
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; a second instance with RETIRE_WIDTH=4 checks counter wrap.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        memValid;
    logic        memRegWrite;
    logic        memMemToReg;
    logic [2:0]  memLoadType;
    logic [1:0]  memByteOffset;
    logic [4:0]  memWriteAddr;
    logic [31:0] memAluResult;
    logic [31:0] memReadData;
    logic [4:0]  writeAddr;
    logic [31:0] writedata;
    logic        writeEnable;
    logic [31:0] retired;
    logic [4:0]  writeAddr4;
    logic [31:0] writedata4;
    logic        writeEnable4;
    logic [3:0]  retired4;
`ifdef WB_FORWARD_EN
    logic [4:0]  addr1;
    logic [4:0]  addr2;
    logic        fwd1;
    logic        fwd2;
    logic [31:0] fwdData1;
    logic [31:0] fwdData2;
    logic        fwd1_4;
    logic        fwd2_4;
    logic [31:0] fwdData1_4;
    logic [31:0] fwdData2_4;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    always #5 clk = ~clk;

    writeback_stage u_dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .memValid      (memValid),
        .memRegWrite   (memRegWrite),
        .memMemToReg   (memMemToReg),
        .memLoadType   (memLoadType),
        .memByteOffset (memByteOffset),
        .memWriteAddr  (memWriteAddr),
        .memAluResult  (memAluResult),
        .memReadData   (memReadData),
        .writeAddr     (writeAddr),
        .writedata     (writedata),
        .writeEnable   (writeEnable),
`ifdef WB_FORWARD_EN
        .addr1         (addr1),
        .addr2         (addr2),
        .fwd1          (fwd1),
        .fwd2          (fwd2),
        .fwdData1      (fwdData1),
        .fwdData2      (fwdData2),
`endif
        .retired       (retired)
    );

    writeback_stage #(.RETIRE_WIDTH(4)) u_dut4 (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .memValid      (memValid),
        .memRegWrite   (memRegWrite),
        .memMemToReg   (memMemToReg),
        .memLoadType   (memLoadType),
        .memByteOffset (memByteOffset),
        .memWriteAddr  (memWriteAddr),
        .memAluResult  (memAluResult),
        .memReadData   (memReadData),
        .writeAddr     (writeAddr4),
        .writedata     (writedata4),
        .writeEnable   (writeEnable4),
`ifdef WB_FORWARD_EN
        .addr1         (addr1),
        .addr2         (addr2),
        .fwd1          (fwd1_4),
        .fwd2          (fwd2_4),
        .fwdData1      (fwdData1_4),
        .fwdData2      (fwdData2_4),
`endif
        .retired       (retired4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic rw, input logic m2r,
                         input logic [2:0] lt, input logic [1:0] off, input logic [4:0] wa,
                         input logic [31:0] alu, input logic [31:0] rd);
        memValid      = v;
        flush         = f;
        memRegWrite   = rw;
        memMemToReg   = m2r;
        memLoadType   = lt;
        memByteOffset = off;
        memWriteAddr  = wa;
        memAluResult  = alu;
        memReadData   = rd;
        if (v && !f) exp_ret++;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  ld_type [10] = '{3'd3, 3'd4, 3'd3, 3'd1, 3'd2, 3'd0, 3'd3, 3'd1, 3'd4, 3'd7};
    logic [1:0]  ld_off  [10] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2, 2'd2};
    logic [31:0] ld_exp  [10] = '{32'hFFFF_FF82, 32'h0000_0082, 32'h0000_007F, 32'hFFFF_80F1,
                                  32'h0000_80F1, 32'h80F1_7F82, 32'hFFFF_FF80, 32'h0000_7F82,
                                  32'h0000_00F1, 32'h80F1_7F82};

    initial begin
        reset = 1'b1;
`ifdef WB_FORWARD_EN
        addr1 = 5'd0;
        addr2 = 5'd0;
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0);
        step();
        step();
        check_eq("reset_we", {31'b0, writeEnable}, 32'h0);
        check_eq("reset_wa", {27'b0, writeAddr}, 32'h0);
        check_eq("reset_wd", writedata, 32'h0);
        check_eq("reset_ret", retired, 32'h0);
        reset = 1'b0;

        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 5'd8, 32'h0000_0022, 32'hFFFF_FFFF);
        step();
        check_eq("add_we", {31'b0, writeEnable}, 32'h1);
        check_eq("add_wa", {27'b0, writeAddr}, 32'd8);
        check_eq("add_wd", writedata, 32'h0000_0022);
        check_eq("add_ret", retired, 32'd1);

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, ld_type[i], ld_off[i], 5'd3, 32'hDEAD_BEEF,
                  32'h80F1_7F82);
            step();
            check_eq($sformatf("load%0d_wd", i), writedata, ld_exp[i]);
        end
        check_eq("load_ret", retired, 32'd11);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 32'h0000_0077, 32'h0);
        step();
        check_eq("zero_we", {31'b0, writeEnable}, 32'h0);
        check_eq("zero_ret", retired, 32'd12);

        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 32'h0000_0099, 32'h0);
        step();
        check_eq("flush_we", {31'b0, writeEnable}, 32'h0);
        check_eq("flush_ret", retired, 32'd12);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 32'h0000_0099, 32'h0);
        step();
        check_eq("w9_we", {31'b0, writeEnable}, 32'h1);
        check_eq("w9_wa", {27'b0, writeAddr}, 32'd9);
        check_eq("w9_wd", writedata, 32'h0000_0099);
        check_eq("w9_ret", retired, 32'd13);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 32'h0000_0099, 32'h0);
        step();
        check_eq("bubble_we", {31'b0, writeEnable}, 32'h0);
        check_eq("bubble_ret", retired, 32'd13);

`ifdef WB_FORWARD_EN
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 5'd10, 32'h0000_1234, 32'h0);
        step();
        addr1 = 5'd10;
        addr2 = 5'd0;
        #1;
        check_eq("fwd1", {31'b0, fwd1}, 32'h1);
        check_eq("fwdData1", fwdData1, 32'h0000_1234);
        check_eq("fwd2", {31'b0, fwd2}, 32'h0);
        check_eq("fwdData2", fwdData2, 32'h0);
`endif
        check_eq("model_ret", retired, exp_ret);

        // Reset in the middle of a cycle with an instruction in flight.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 5'd5, 32'h0000_0055, 32'h0);
        step();
        check_eq("pre_rst_we", {31'b0, writeEnable}, 32'h1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 5'd6, 32'h0000_0066, 32'h0);
        #3;
        reset = 1'b1;
        #1;
        check_eq("midrst_we", {31'b0, writeEnable}, 32'h0);
        check_eq("midrst_wa", {27'b0, writeAddr}, 32'h0);
        check_eq("midrst_wd", writedata, 32'h0);
        check_eq("midrst_ret", retired, 32'h0);
        check_eq("midrst_ret4", {28'b0, retired4}, 32'h0);
        step();
        check_eq("held_rst_we", {31'b0, writeEnable}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd1, 32'(i), 32'h0);
            step();
        end
        check_eq("ret4_15", {28'b0, retired4}, 32'd15);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd1, 32'h0, 32'h0);
        step();
        check_eq("ret4_wrap", {28'b0, retired4}, 32'd0);
        check_eq("ret32_16", retired, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
